// File: rtl/bcd_key_entry_pkg.sv
// ---------------------------------------------------------------------------
// calc_pkg
// Shared definitions for the BCD calculator key-entry front end.
//   - Key codes as delivered by the upstream keypad scanner
//   - ALU opcodes driven towards the combinational ALU stage
//   - Entry state machine encoding
//   - keyToOpcode helper mapping an operator key onto its ALU opcode
// ---------------------------------------------------------------------------
package calc_pkg;

    // Key codes: 0-9 are digits; everything from 17 upwards is unused
    localparam int K_DIGIT_MAX = 9;
    localparam int K_ADD       = 10;
    localparam int K_SUB       = 11;
    localparam int K_MUL       = 12;
    localparam int K_DIV       = 13;
    localparam int K_EQUALS    = 14;
    localparam int K_SIGN      = 15;
    localparam int K_CLEAR     = 16;

    // ALU opcodes
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_MUL = 3'b011;
    localparam logic [2:0] OP_DIV = 3'b100;

    // Entry state machine
    typedef enum logic [1:0] {
        ENTER_OP1 = 2'd0,
        ENTER_OP2 = 2'd1,
        EXEC      = 2'd2,
        SHOW      = 2'd3
    } state_t;

    // Operator keys 10..13 are distinguished by their low three bits
    // (010, 011, 100, 101), which keeps the mapping independent of KEY_W.
    function automatic logic [2:0] keyToOpcode(input logic [2:0] keyLow);
        logic [2:0] opcode;
        case (keyLow)
            3'b010:  opcode = OP_ADD;
            3'b011:  opcode = OP_SUB;
            3'b100:  opcode = OP_MUL;
            3'b101:  opcode = OP_DIV;
            default: opcode = OP_ADD;
        endcase
        return opcode;
    endfunction

endpackage

// File: rtl/bcd_operand_reg.sv
// ---------------------------------------------------------------------------
// bcd_operand_reg
// One sign-magnitude BCD operand {sign, tens, ones} plus a count of the
// digits typed into it so far.
//
// Ports
//   i_clk        system clock, rising edge
//   i_nrst       asynchronous active-low reset
//   i_clear      synchronous clear of value and count
//   i_load       load i_loadValue / i_loadCount
//   i_loadValue  9-bit value to load
//   i_loadCount  digit count to load alongside the value
//   i_shift      shift i_digit into the ones position
//   i_digit      BCD digit to shift in
//   i_toggle     invert the sign bit
//   o_value      current operand {sign, tens, ones}
//   o_count      number of digits entered (saturates at 2)
//
// Priority when several controls are asserted: clear, load, shift, toggle.
// ---------------------------------------------------------------------------
module bcd_operand_reg (
    input  logic       i_clk,
    input  logic       i_nrst,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [8:0] i_loadValue,
    input  logic [1:0] i_loadCount,
    input  logic       i_shift,
    input  logic [3:0] i_digit,
    input  logic       i_toggle,
    output logic [8:0] o_value,
    output logic [1:0] o_count
);

    logic [8:0] r_value;
    logic [1:0] r_count;

    // Operand storage. Once two digits are in, further digits are dropped
    // so the operand never silently loses its tens digit. The sign bit is
    // only ever touched by the toggle or a load/clear.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_value <= 9'h000;
            r_count <= 2'd0;
        end else if (i_clear) begin
            r_value <= 9'h000;
            r_count <= 2'd0;
        end else if (i_load) begin
            r_value <= i_loadValue;
            r_count <= i_loadCount;
        end else if (i_shift) begin
            if (r_count < 2'd2) begin
                r_value <= {r_value[8], r_value[3:0], i_digit};
                r_count <= r_count + 2'd1;
            end
        end else if (i_toggle) begin
            r_value[8] <= ~r_value[8];
        end
    end

    assign o_value = r_value;
    assign o_count = r_count;

endmodule

// File: rtl/bcd_key_entry.sv
// ---------------------------------------------------------------------------
// bcd_key_entry
// Operand-entry front end for the BCD calculator. Converts key strobes into
// two sign-magnitude BCD operands and an opcode, fires a one-cycle alu_en
// into the combinational ALU, and captures its result for display and for
// chaining into the next operation.
//
// Ports
//   i_clk        system clock, rising edge
//   i_nrst       asynchronous active-low reset
//   i_key_valid  one-cycle key strobe
//   i_key_code   0-9 digit, 10 add, 11 sub, 12 mul, 13 div, 14 equals,
//                15 sign toggle, 16 clear; other codes ignored
//   o_op1        first operand {sign, tens, ones}
//   o_op2        second operand, same format
//   o_opcode     001 add, 010 sub, 011 mul, 100 div
//   o_alu_en     one-cycle execute strobe to the ALU
//   i_result     ALU result, sampled only while o_alu_en is high
//   o_display    value to show, same 9-bit format
//   o_err        divide-by-zero flag
// ---------------------------------------------------------------------------
module bcd_key_entry
    import calc_pkg::*;
#(
    parameter int KEY_W = 5
) (
    input  logic             i_clk,
    input  logic             i_nrst,
    input  logic             i_key_valid,
    input  logic [KEY_W-1:0] i_key_code,
    output logic [8:0]       o_op1,
    output logic [8:0]       o_op2,
    output logic [2:0]       o_opcode,
    output logic             o_alu_en,
    input  logic [8:0]       i_result,
    output logic [8:0]       o_display,
    output logic             o_err
);

    state_t     r_state;
    logic [2:0] r_opcode;
    logic [8:0] r_res;
    logic       r_err;

    logic [8:0] w_op1;
    logic [8:0] w_op2;
    logic [1:0] w_op1Count;
    logic [1:0] w_op2Count;

    logic       w_isDigit;
    logic       w_isOperator;
    logic       w_isEquals;
    logic       w_isSign;
    logic       w_isClear;
    logic [3:0] w_digit;
    logic [2:0] w_keyOpcode;
    logic       w_div0;

    logic       w_op1Clear;
    logic       w_op1Load;
    logic [8:0] w_op1LoadValue;
    logic [1:0] w_op1LoadCount;
    logic       w_op1Shift;
    logic       w_op1Toggle;
    logic       w_op2Clear;
    logic       w_op2Shift;
    logic       w_op2Toggle;

    // Key classification. Keys arriving during EXEC are dropped outright,
    // so every class is qualified with "not in EXEC" here once.
    always_comb begin
        logic accept;
        accept       = i_key_valid && (r_state != EXEC);
        w_isDigit    = accept && (i_key_code <= KEY_W'(K_DIGIT_MAX));
        w_isOperator = accept && (i_key_code >= KEY_W'(K_ADD)) &&
                       (i_key_code <= KEY_W'(K_DIV));
        w_isEquals   = accept && (i_key_code == KEY_W'(K_EQUALS));
        w_isSign     = accept && (i_key_code == KEY_W'(K_SIGN));
        w_isClear    = accept && (i_key_code == KEY_W'(K_CLEAR));
        w_digit      = i_key_code[3:0];
        w_keyOpcode  = keyToOpcode(i_key_code[2:0]);
    end

    // A divide with a zero magnitude divisor never reaches the ALU.
    assign w_div0 = (r_opcode == OP_DIV) && (w_op2[7:0] == 8'h00);

    // Operand control decode. Loads of op1 from the held result happen on
    // the same edge as the state change so the ALU sees the chained value
    // for the whole EXEC cycle.
    always_comb begin
        w_op1Clear     = 1'b0;
        w_op1Load      = 1'b0;
        w_op1LoadValue = 9'h000;
        w_op1LoadCount = 2'd0;
        w_op1Shift     = 1'b0;
        w_op1Toggle    = 1'b0;
        w_op2Clear     = 1'b0;
        w_op2Shift     = 1'b0;
        w_op2Toggle    = 1'b0;

        if (w_isClear) begin
            w_op1Clear = 1'b1;
            w_op2Clear = 1'b1;
        end else begin
            case (r_state)
                ENTER_OP1: begin
                    w_op1Shift  = w_isDigit;
                    w_op1Toggle = w_isSign;
                    w_op2Clear  = w_isOperator;
                end
                ENTER_OP2: begin
                    w_op2Shift  = w_isDigit;
                    w_op2Toggle = w_isSign;
                end
                SHOW: begin
                    if (w_isOperator || w_isEquals) begin
                        w_op1Load      = 1'b1;
                        w_op1LoadValue = r_res;
                        w_op1LoadCount = 2'd2;
                    end else if (w_isDigit) begin
                        w_op1Load      = 1'b1;
                        w_op1LoadValue = {5'b00000, w_digit};
                        w_op1LoadCount = 2'd1;
                    end
                    w_op2Clear = w_isOperator;
                end
                default: ;
            endcase
        end
    end

    bcd_operand_reg u_op1 (
        .i_clk       (i_clk),
        .i_nrst      (i_nrst),
        .i_clear     (w_op1Clear),
        .i_load      (w_op1Load),
        .i_loadValue (w_op1LoadValue),
        .i_loadCount (w_op1LoadCount),
        .i_shift     (w_op1Shift),
        .i_digit     (w_digit),
        .i_toggle    (w_op1Toggle),
        .o_value     (w_op1),
        .o_count     (w_op1Count)
    );

    bcd_operand_reg u_op2 (
        .i_clk       (i_clk),
        .i_nrst      (i_nrst),
        .i_clear     (w_op2Clear),
        .i_load      (1'b0),
        .i_loadValue (9'h000),
        .i_loadCount (2'd0),
        .i_shift     (w_op2Shift),
        .i_digit     (w_digit),
        .i_toggle    (w_op2Toggle),
        .o_value     (w_op2),
        .o_count     (w_op2Count)
    );

    // Entry state machine with opcode, captured result and error flag.
    // An operator typed before any op2 digit is treated as a correction of
    // the pending opcode; once op2 has digits the operator is ignored.
    always_ff @(posedge i_clk or negedge i_nrst) begin
        if (!i_nrst) begin
            r_state  <= ENTER_OP1;
            r_opcode <= OP_ADD;
            r_res    <= 9'h000;
            r_err    <= 1'b0;
        end else if (w_isClear) begin
            r_state  <= ENTER_OP1;
            r_opcode <= OP_ADD;
            r_res    <= 9'h000;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ENTER_OP1: begin
                    if (w_isDigit || w_isOperator) begin
                        r_err <= 1'b0;
                    end
                    if (w_isOperator) begin
                        r_opcode <= w_keyOpcode;
                        r_state  <= ENTER_OP2;
                    end
                end
                ENTER_OP2: begin
                    if (w_isDigit || w_isOperator) begin
                        r_err <= 1'b0;
                    end
                    if (w_isOperator && (w_op2Count == 2'd0)) begin
                        r_opcode <= w_keyOpcode;
                    end
                    if (w_isEquals) begin
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    if (w_div0) begin
                        r_res <= 9'h000;
                        r_err <= 1'b1;
                    end else begin
                        r_res <= i_result;
                    end
                    r_state <= SHOW;
                end
                SHOW: begin
                    if (w_isOperator) begin
                        r_err    <= 1'b0;
                        r_opcode <= w_keyOpcode;
                        r_state  <= ENTER_OP2;
                    end else if (w_isDigit) begin
                        r_err   <= 1'b0;
                        r_state <= ENTER_OP1;
                    end else if (w_isSign) begin
                        r_res[8] <= ~r_res[8];
                    end else if (w_isEquals) begin
                        r_state <= EXEC;
                    end
                end
                default: r_state <= ENTER_OP1;
            endcase
        end
    end

    // Decoded straight from the state register so a reset in EXEC drops
    // the strobe immediately.
    assign o_alu_en = (r_state == EXEC) && !w_div0;

    // Display selection: while op2 is still empty keep showing op1.
    always_comb begin
        o_display = w_op1;
        case (r_state)
            ENTER_OP1: o_display = w_op1;
            ENTER_OP2: o_display = (w_op2Count != 2'd0) ? w_op2 : w_op1;
            EXEC:      o_display = w_op2;
            SHOW:      o_display = r_res;
            default:   o_display = w_op1;
        endcase
    end

    assign o_op1    = w_op1;
    assign o_op2    = w_op2;
    assign o_opcode = r_opcode;
    assign o_err    = r_err;

endmodule

// File: tb/tb_bcd_key_entry.sv
// ---------------------------------------------------------------------------
// tb_bcd_key_entry
// Directed testbench for bcd_key_entry. Keys are strobed on the falling
// clock edge so the DUT samples them on the following rising edge, and all
// outputs are compared on falling edges (or a few ns after an async reset).
// ---------------------------------------------------------------------------
module tb_bcd_key_entry;

    logic       clk;
    logic       nrst;
    logic       keyValid;
    logic [4:0] keyCode;
    logic [8:0] op1;
    logic [8:0] op2;
    logic [2:0] opcode;
    logic       aluEn;
    logic [8:0] result;
    logic [8:0] display;
    logic       err;

    int assertCount = 0;
    int failCount   = 0;
    int aluPulses   = 0;
    int pulseBase;

    bcd_key_entry #(.KEY_W(5)) dut (
        .i_clk       (clk),
        .i_nrst      (nrst),
        .i_key_valid (keyValid),
        .i_key_code  (keyCode),
        .o_op1       (op1),
        .o_op2       (op2),
        .o_opcode    (opcode),
        .o_alu_en    (aluEn),
        .i_result    (result),
        .o_display   (display),
        .o_err       (err)
    );

    // 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count alu_en cycles, sampled mid-cycle on the falling edge
    always @(negedge clk) begin
        if (aluEn) aluPulses++;
    end

    // Guard against a stuck simulation
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Compare one observed value against its expected value
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Strobe one key for a single cycle; call from a falling edge
    task automatic applyStimulus(input int code);
        keyValid = 1'b1;
        keyCode  = code[4:0];
        @(negedge clk);
        keyValid = 1'b0;
        keyCode  = 5'd0;
    endtask

    initial begin
        nrst     = 1'b0;
        keyValid = 1'b0;
        keyCode  = 5'd0;
        result   = 9'h000;
        repeat (2) @(negedge clk);

        // Reset state
        checkOutput("reset_display", display, 9'h000);
        checkOutput("reset_alu_en",  aluEn,   1'b0);
        checkOutput("reset_err",     err,     1'b0);
        checkOutput("reset_opcode",  opcode,  3'b001);
        checkOutput("reset_op1",     op1,     9'h000);
        checkOutput("reset_op2",     op2,     9'h000);
        nrst = 1'b1;
        @(negedge clk);

        // 12 + 34
        applyStimulus(1);
        applyStimulus(2);
        checkOutput("add_op1_entry", op1, 9'h012);
        applyStimulus(10);
        checkOutput("add_disp_after_op", display, 9'h012);
        checkOutput("add_opcode", opcode, 3'b001);
        applyStimulus(3);
        applyStimulus(4);
        checkOutput("add_disp_op2", display, 9'h034);
        result    = 9'h046;
        pulseBase = aluPulses;
        applyStimulus(14);
        checkOutput("add_exec_alu_en", aluEn, 1'b1);
        checkOutput("add_exec_op1", op1, 9'h012);
        checkOutput("add_exec_op2", op2, 9'h034);
        checkOutput("add_exec_opcode", opcode, 3'b001);
        @(negedge clk);
        checkOutput("add_show_alu_en", aluEn, 1'b0);
        checkOutput("add_show_display", display, 9'h046);
        checkOutput("add_pulse_count", aluPulses - pulseBase, 1);

        // Chain: 046 + 1, with a digit strobed during EXEC
        applyStimulus(10);
        checkOutput("chain_disp_op1", display, 9'h046);
        applyStimulus(1);
        result    = 9'h047;
        pulseBase = aluPulses;
        applyStimulus(14);
        checkOutput("chain_exec_alu_en", aluEn, 1'b1);
        checkOutput("chain_exec_op1", op1, 9'h046);
        checkOutput("chain_exec_op2", op2, 9'h001);
        checkOutput("chain_exec_opcode", opcode, 3'b001);
        keyValid = 1'b1;
        keyCode  = 5'd5;
        @(negedge clk);
        keyValid = 1'b0;
        keyCode  = 5'd0;
        checkOutput("chain_show_display", display, 9'h047);
        checkOutput("chain_drop_op1", op1, 9'h046);
        checkOutput("chain_pulse_count", aluPulses - pulseBase, 1);
        @(negedge clk);

        // Clear, then -5 - 7
        applyStimulus(16);
        checkOutput("clear_display", display, 9'h000);
        checkOutput("clear_opcode", opcode, 3'b001);
        applyStimulus(5);
        applyStimulus(15);
        checkOutput("sub_op1_signed", op1, 9'h105);
        applyStimulus(11);
        checkOutput("sub_opcode", opcode, 3'b010);
        checkOutput("sub_disp_op1", display, 9'h105);
        applyStimulus(7);
        result    = 9'h112;
        pulseBase = aluPulses;
        applyStimulus(14);
        checkOutput("sub_exec_alu_en", aluEn, 1'b1);
        checkOutput("sub_exec_op1", op1, 9'h105);
        checkOutput("sub_exec_op2", op2, 9'h007);
        @(negedge clk);
        checkOutput("sub_show_display", display, 9'h112);
        checkOutput("sub_pulse_count", aluPulses - pulseBase, 1);

        // Divide by zero
        applyStimulus(16);
        applyStimulus(7);
        applyStimulus(13);
        checkOutput("div_opcode", opcode, 3'b100);
        applyStimulus(0);
        result    = 9'h099;
        pulseBase = aluPulses;
        applyStimulus(14);
        checkOutput("div0_exec_alu_en", aluEn, 1'b0);
        @(negedge clk);
        checkOutput("div0_err", err, 1'b1);
        checkOutput("div0_display", display, 9'h000);
        checkOutput("div0_pulse_count", aluPulses - pulseBase, 0);
        applyStimulus(3);
        checkOutput("div0_err_cleared", err, 1'b0);
        checkOutput("div0_next_digit", display, 9'h003);

        // Third digit ignored, operator correction before op2 digits
        applyStimulus(16);
        applyStimulus(1);
        applyStimulus(2);
        applyStimulus(3);
        checkOutput("sat_op1", op1, 9'h012);
        applyStimulus(10);
        applyStimulus(12);
        checkOutput("replace_opcode", opcode, 3'b011);
        checkOutput("replace_display", display, 9'h012);

        // Reset pulsed mid-entry
        applyStimulus(16);
        applyStimulus(1);
        applyStimulus(2);
        checkOutput("midentry_op1", op1, 9'h012);
        #2 nrst = 1'b0;
        #1;
        checkOutput("midentry_rst_op1", op1, 9'h000);
        checkOutput("midentry_rst_display", display, 9'h000);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);

        // Reset pulsed during EXEC: no capture
        applyStimulus(1);
        applyStimulus(10);
        applyStimulus(2);
        result = 9'h003;
        applyStimulus(14);
        checkOutput("rstexec_alu_en_before", aluEn, 1'b1);
        #2 nrst = 1'b0;
        #1;
        checkOutput("rstexec_alu_en_drop", aluEn, 1'b0);
        checkOutput("rstexec_display", display, 9'h000);
        checkOutput("rstexec_op1", op1, 9'h000);
        checkOutput("rstexec_opcode", opcode, 3'b001);
        @(negedge clk);
        nrst = 1'b1;
        @(negedge clk);
        checkOutput("rstexec_no_capture", display, 9'h000);
        checkOutput("rstexec_err", err, 1'b0);
        checkOutput("rstexec_alu_en_after", aluEn, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
